// File: rtl/music_pkg.sv
// Shared definitions for the music-player audio path: sample/gain widths
// and the gain-ramp state encoding.
package music_pkg;

   localparam int SAMPLE_W   = 16;
   localparam int GAIN_W     = 8;
   localparam int UNITY_GAIN = 1 << GAIN_W;

   typedef enum logic [1:0] {
      MUTED     = 2'd0,
      RAMP_UP   = 2'd1,
      STEADY    = 2'd2,
      RAMP_DOWN = 2'd3
   } ramp_state_t;

endpackage

// File: rtl/sample_volume_ramp_gain_ramp.sv
// gain_ramp: user volume register, play-gated target gain and the applied
// gain that the datapath multiplies by.
// Build option VOL_RAMP_EN: when defined, the applied gain slews toward the
// target by at most RAMP_STEP per frame and a state machine tracks the
// ramp; when undefined, the gain jumps to the target on the next frame.
module gain_ramp #(
   parameter int GAIN_W    = music_pkg::GAIN_W,
   parameter int VOL_STEP  = 32,
   parameter int VOL_RESET = music_pkg::UNITY_GAIN / 2,
   parameter int RAMP_STEP = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            new_frame_i,
   input  logic            play_i,
   input  logic            vol_up_i,
   input  logic            vol_down_i,
   output logic [GAIN_W:0] gain_o,
   output logic            muted_o
);

   import music_pkg::*;

   localparam int            GW       = GAIN_W + 1;
   localparam logic [GW-1:0] UNITY    = GW'(1 << GAIN_W);
   localparam logic [GW-1:0] STEP_V   = GW'(VOL_STEP);
   localparam logic [GW-1:0] VOL_INIT = GW'(VOL_RESET);

   logic [GW-1:0] vol_q, vol_d;
   logic [GW-1:0] target;
   logic [GW-1:0] gain_q, gain_d;

   // Volume next-state: saturating up/down, simultaneous presses cancel
   always_comb begin
      // NOTE: default assignment first so every path drives vol_d and no latch is inferred.
      vol_d = vol_q;
      if (vol_up_i && !vol_down_i) begin
         vol_d = (vol_q > UNITY - STEP_V) ? UNITY : vol_q + STEP_V;
      end else if (vol_down_i && !vol_up_i) begin
         vol_d = (vol_q < STEP_V) ? '0 : vol_q - STEP_V;
      end
   end

   // Volume register
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!reset) vol_q <= VOL_INIT;
      else        vol_q <= vol_d;
   end

   // Pausing simply targets silence; the applied gain then fades to it
   assign target = play_i ? vol_q : '0;

`ifdef VOL_RAMP_EN
   localparam logic [GW-1:0] RSTEP = GW'(RAMP_STEP);

   ramp_state_t state_q;
   logic        muted_q;

   // Slew the applied gain toward target by at most RSTEP, landing exactly on it
   always_comb begin
      gain_d = gain_q;
      if (new_frame_i) begin
         if (target > gain_q) begin
            gain_d = (target - gain_q > RSTEP) ? gain_q + RSTEP : target;
         end else if (target < gain_q) begin
            gain_d = (gain_q - target > RSTEP) ? gain_q - RSTEP : target;
         end
      end
   end

   // Ramp state and registered muted flag, classified from the post-step gain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= MUTED;
         muted_q <= 1'b1;
      end else if (new_frame_i) begin
         if (gain_d == '0 && target == '0) begin
            state_q <= MUTED;
            muted_q <= 1'b1;
         end else begin
            muted_q <= 1'b0;
            if (gain_d < target)      state_q <= RAMP_UP;
            else if (gain_d > target) state_q <= RAMP_DOWN;
            else                      state_q <= STEADY;
         end
      end
   end

   assign muted_o = muted_q;
`else
   // Without ramping the step size has no effect
   localparam int unused_ramp_step = RAMP_STEP;

   // Jump straight to target on each frame
   always_comb begin
      gain_d = new_frame_i ? target : gain_q;
   end

   assign muted_o = (gain_q == '0);
`endif

   // Applied gain register; restarts from silence after reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) gain_q <= '0;
      else        gain_q <= gain_d;
   end

   assign gain_o = gain_q;

endmodule

// File: rtl/sample_volume_ramp.sv
// sample_volume_ramp: output-volume stage between the music player and the
// codec interface. Scales each frame's sample by the applied gain from
// gain_ramp through a two-register capture/multiply pipeline.
// Build option VOL_RAMP_EN selects per-frame gain slewing (see gain_ramp);
// the datapath and its latency are identical in both builds.
module sample_volume_ramp #(
   parameter int SAMPLE_W  = music_pkg::SAMPLE_W,
   parameter int GAIN_W    = music_pkg::GAIN_W,
   parameter int VOL_STEP  = 32,
   parameter int VOL_RESET = music_pkg::UNITY_GAIN / 2,
   parameter int RAMP_STEP = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                new_frame,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                play,
   input  logic                vol_up,
   input  logic                vol_down,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                out_valid,
   output logic [GAIN_W:0]     gain,
   output logic                muted
);

   import music_pkg::*;

   localparam int PW = SAMPLE_W + GAIN_W + 2;

   logic [GAIN_W:0]            gain_cur;
   logic signed [SAMPLE_W-1:0] smp_q;
   logic [GAIN_W:0]            cap_gain_q;
   logic                       cap_vld_q;
   logic signed [PW-1:0]       prod;
   logic signed [SAMPLE_W-1:0] scaled_q;
   logic                       out_vld_q;
   logic                       unused_prod_bits;

   gain_ramp #(
      .GAIN_W    (GAIN_W),
      .VOL_STEP  (VOL_STEP),
      .VOL_RESET (VOL_RESET),
      .RAMP_STEP (RAMP_STEP)
   ) u_gain_ramp (
      .clk         (clk),
      .reset       (reset),
      .new_frame_i (new_frame),
      .play_i      (play),
      .vol_up_i    (vol_up),
      .vol_down_i  (vol_down),
      .gain_o      (gain_cur),
      .muted_o     (muted)
   );

   // Capture stage: sample plus the gain in effect before this frame's update
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         smp_q      <= '0;
         cap_gain_q <= '0;
         cap_vld_q  <= 1'b0;
      end else begin
         cap_vld_q <= new_frame;
         if (new_frame) begin
            smp_q      <= signed'(sample_in);
            cap_gain_q <= gain_cur;
         end
      end
   end

   // Signed sample times non-negative gain; the zero-extended gain keeps unity positive
   assign prod = PW'(smp_q) * PW'($signed({1'b0, cap_gain_q}));

   // Since gain never exceeds unity, the top bits are sign copies and the
   // low GAIN_W bits are the fraction discarded by the floor shift
   assign unused_prod_bits = ^{prod[PW-1:GAIN_W+SAMPLE_W], prod[GAIN_W-1:0]};

   // Output stage: arithmetic shift by GAIN_W (floor), held between frames
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scaled_q  <= '0;
         out_vld_q <= 1'b0;
      end else begin
         out_vld_q <= cap_vld_q;
         if (cap_vld_q) scaled_q <= prod[GAIN_W +: SAMPLE_W];
      end
   end

   assign sample_out = scaled_q;
   assign out_valid  = out_vld_q;
   assign gain       = gain_cur;

endmodule
